// File: rtl/nap_seq_if.sv
// Host-side bundle for the purification sequencer: run request inputs plus registered chip control lines.
// NAP_SEQ_PAUSE_EN adds the pause input.
interface nap_seq_if #(
  parameter int SIZE = 8,
  parameter int SELW = 3
);
  // start is a single-cycle request with no ready: it is taken only in IDLE, and err flags a bad sample_sel.
  logic            start;
  logic [SELW-1:0] sample_sel;
  logic            abort;
`ifdef NAP_SEQ_PAUSE_EN
  logic            pause;
`endif
  logic [10:0]     valve;
  logic [2:0]      pump;
  logic [SIZE-1:0] collect_en;
  logic            busy;
  logic            done;
  logic            err;
  logic            aborted;
  logic [3:0]      state_dbg;

`ifdef NAP_SEQ_PAUSE_EN
  modport master (
    output start, sample_sel, abort, pause,
    input  valve, pump, collect_en, busy, done, err, aborted, state_dbg
  );
  modport slave (
    input  start, sample_sel, abort, pause,
    output valve, pump, collect_en, busy, done, err, aborted, state_dbg
  );
`else
  modport master (
    output start, sample_sel, abort,
    input  valve, pump, collect_en, busy, done, err, aborted, state_dbg
  );
  modport slave (
    input  start, sample_sel, abort,
    output valve, pump, collect_en, busy, done, err, aborted, state_dbg
  );
`endif
endinterface

// File: rtl/nap_seq_ctrl.sv
// Protocol sequencer: bead load, cell load, lysis, mix, trap, wash, elute, with all-closed gaps in between.
// Optional NAP_SEQ_PAUSE_EN freezes counters and stops the pump while pause is high.
module nap_seq_ctrl #(
  parameter int SIZE        = 8,
  parameter int SELW        = 3,
  parameter int PUMP_DIV    = 4,
  parameter int LOAD_STEPS  = 12,
  parameter int MIX_STEPS   = 48,
  parameter int WASH_STEPS  = 24,
  parameter int ELUTE_STEPS = 12,
  parameter int DWELL       = 16,
  parameter int GAP         = 2
) (
  input logic      clk,
  input logic      rst,
  nap_seq_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, BEAD_LOAD, CELL_LOAD, LYSIS, MIX, TRAP, WASH, ELUTE, GAPST, DONE
  } state_t;

  localparam logic [15:0] LOAD_LEN  = 16'(LOAD_STEPS * PUMP_DIV);
  localparam logic [15:0] MIX_LEN   = 16'(MIX_STEPS * PUMP_DIV);
  localparam logic [15:0] WASH_LEN  = 16'(WASH_STEPS * PUMP_DIV);
  localparam logic [15:0] ELUTE_LEN = 16'(ELUTE_STEPS * PUMP_DIV);
  localparam logic [15:0] DWELL_LEN = 16'(DWELL);
  localparam logic [15:0] GAP_LEN   = 16'(GAP);
  localparam logic [15:0] DIV_LAST  = 16'(PUMP_DIV - 1);

  state_t          state, state_n, nxt, nxt_n;
  logic [15:0]     cnt, cnt_n, div, div_n;
  logic [1:0]      ph, ph_n;
  logic [SELW-1:0] sel, sel_n;
  logic            paused;

  logic [10:0]     valve_q, valve_n;
  logic [2:0]      pump_q, pump_n;
  logic [SIZE-1:0] collect_q, collect_n;
  logic            busy_q, busy_n, done_q, done_n, err_q, err_n, aborted_q, aborted_n;

  function automatic logic [15:0] stage_len(input state_t s);
    case (s)
      BEAD_LOAD, CELL_LOAD: stage_len = LOAD_LEN;
      MIX:                  stage_len = MIX_LEN;
      WASH:                 stage_len = WASH_LEN;
      ELUTE:                stage_len = ELUTE_LEN;
      LYSIS, TRAP:          stage_len = DWELL_LEN;
      GAPST:                stage_len = GAP_LEN;
      default:              stage_len = 16'd1;
    endcase
  endfunction

  function automatic logic is_pumped(input state_t s);
    is_pumped = (s == BEAD_LOAD) || (s == CELL_LOAD) || (s == MIX) || (s == WASH) || (s == ELUTE);
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      BEAD_LOAD: succ = CELL_LOAD;
      CELL_LOAD: succ = LYSIS;
      LYSIS:     succ = MIX;
      MIX:       succ = TRAP;
      TRAP:      succ = WASH;
      WASH:      succ = ELUTE;
      default:   succ = IDLE;
    endcase
  endfunction

  // Bits: 0 lysis, 1 wash, 2 elute, 3 dead_end, 4 vertical, 5 horiz, 6 waste, 7 bead, 8 loop_exit, 9 bead_trap, 10 collect.
  function automatic logic [10:0] valve_of(input state_t s);
    case (s)
      BEAD_LOAD: valve_of = 11'h0E0;
      CELL_LOAD: valve_of = 11'h070;
      LYSIS:     valve_of = 11'h019;
      MIX:       valve_of = 11'h030;
      TRAP:      valve_of = 11'h340;
      WASH:      valve_of = 11'h242;
      ELUTE:     valve_of = 11'h604;
      default:   valve_of = 11'h000;
    endcase
  endfunction

  function automatic logic [2:0] pump_of(input logic [1:0] p);
    case (p)
      2'd0:    pump_of = 3'b011;
      2'd1:    pump_of = 3'b110;
      2'd2:    pump_of = 3'b101;
      default: pump_of = 3'b111;
    endcase
  endfunction

  always_comb begin
    state_n   = state;
    nxt_n     = nxt;
    cnt_n     = cnt;
    div_n     = div;
    ph_n      = ph;
    sel_n     = sel;
    paused    = 1'b0;
    err_n     = 1'b0;
    aborted_n = 1'b0;
    if (state == IDLE) begin
      if (bus.start) begin
        if (32'(bus.sample_sel) < SIZE) begin
          state_n = BEAD_LOAD;
          sel_n   = bus.sample_sel;
          cnt_n   = 16'd0;
          div_n   = 16'd0;
          ph_n    = 2'd0;
        end else begin
          err_n = 1'b1;
        end
      end
    end else if (bus.abort) begin
      state_n   = IDLE;
      cnt_n     = 16'd0;
      div_n     = 16'd0;
      ph_n      = 2'd0;
      aborted_n = 1'b1;
    end
`ifdef NAP_SEQ_PAUSE_EN
    else if (bus.pause) begin
      paused = 1'b1;
    end
`endif
    else if (state == DONE) begin
      state_n = IDLE;
    end else if (cnt == stage_len(state) - 16'd1) begin
      // Every stage and gap entry starts the pump at phase 0 with a fresh divider.
      cnt_n = 16'd0;
      div_n = 16'd0;
      ph_n  = 2'd0;
      if (state == GAPST) begin
        state_n = nxt;
      end else if (state == ELUTE) begin
        state_n = DONE;
      end else begin
        state_n = GAPST;
        nxt_n   = succ(state);
      end
    end else begin
      cnt_n = cnt + 16'd1;
      if (div == DIV_LAST) begin
        div_n = 16'd0;
        ph_n  = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
      end else begin
        div_n = div + 16'd1;
      end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state register.
    valve_n   = valve_of(state_n);
    pump_n    = is_pumped(state_n) ? pump_of(ph_n) : 3'b111;
    collect_n = (state_n == ELUTE) ? ({{(SIZE-1){1'b0}}, 1'b1} << sel_n) : '0;
    busy_n    = (state_n != IDLE);
    done_n    = (state_n == DONE);
    if (paused) pump_n = 3'b111;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      nxt       <= IDLE;
      cnt       <= 16'd0;
      div       <= 16'd0;
      ph        <= 2'd0;
      sel       <= '0;
      valve_q   <= 11'h000;
      pump_q    <= 3'b111;
      collect_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= state_n;
      nxt       <= nxt_n;
      cnt       <= cnt_n;
      div       <= div_n;
      ph        <= ph_n;
      sel       <= sel_n;
      valve_q   <= valve_n;
      pump_q    <= pump_n;
      collect_q <= collect_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
      err_q     <= err_n;
      aborted_q <= aborted_n;
    end
  end

  assign bus.valve      = valve_q;
  assign bus.pump       = pump_q;
  assign bus.collect_en = collect_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.aborted    = aborted_q;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_nap_seq_ctrl.sv
// Directed bench for nap_seq_ctrl: an independent stage-table model pushes per-cycle expected outputs.
// With NAP_SEQ_PAUSE_EN defined it also runs a 20-clock pause inside MIX.
module tb_nap_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nap_seq_if #(.SIZE(8), .SELW(3)) bus ();
  nap_seq_if #(.SIZE(8), .SELW(4)) bus2 ();

  nap_seq_ctrl #(.SIZE(8), .SELW(3)) dut (.clk(clk), .rst(rst), .bus(bus));
  nap_seq_ctrl #(.SIZE(8), .SELW(4)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  localparam int W = 26;
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Word layout: {err, aborted, busy, done, collect_en[7:0], valve[10:0], pump[2:0]}.
  function automatic logic [W-1:0] mk(input logic e, input logic ab, input logic b, input logic d,
                                      input logic [7:0] c, input logic [10:0] v, input logic [2:0] p);
    mk = {e, ab, b, d, c, v, p};
  endfunction

  function automatic logic [W-1:0] obs1();
    obs1 = {bus.err, bus.aborted, bus.busy, bus.done, bus.collect_en, bus.valve, bus.pump};
  endfunction

  function automatic logic [W-1:0] obs2();
    obs2 = {bus2.err, bus2.aborted, bus2.busy, bus2.done, bus2.collect_en, bus2.valve, bus2.pump};
  endfunction

  // Stage table in protocol order: bead, cell, lysis, mix, trap, wash, elute.
  function automatic int st_len(input int s);
    case (s)
      0, 1, 6: st_len = 12 * 4;
      3:       st_len = 48 * 4;
      5:       st_len = 24 * 4;
      default: st_len = 16;
    endcase
  endfunction

  function automatic logic [10:0] st_valve(input int s);
    case (s)
      0:       st_valve = 11'h0E0;
      1:       st_valve = 11'h070;
      2:       st_valve = 11'h019;
      3:       st_valve = 11'h030;
      4:       st_valve = 11'h340;
      5:       st_valve = 11'h242;
      default: st_valve = 11'h604;
    endcase
  endfunction

  function automatic logic [2:0] pat(input int i);
    case (i)
      0:       pat = 3'b011;
      1:       pat = 3'b110;
      default: pat = 3'b101;
    endcase
  endfunction

  task automatic push_run(input int sel, input int limit, input int pause_at, input int pause_len);
    logic [W-1:0] tmp[$];
    logic [2:0]   p;
    logic [7:0]   c;
    for (int s = 0; s < 7; s++) begin
      for (int i = 0; i < st_len(s); i++) begin
        p = (s == 2 || s == 4) ? 3'b111 : pat((i / 4) % 3);
        c = (s == 6) ? (8'd1 << sel) : 8'd0;
        tmp.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, c, st_valve(s), p));
        if (s == 3 && i == pause_at)
          for (int k = 0; k < pause_len; k++)
            tmp.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, st_valve(3), 3'b111));
      end
      if (s < 6)
        for (int g = 0; g < 2; g++) tmp.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 11'h0, 3'b111));
    end
    tmp.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 8'd0, 11'h0, 3'b111));
    tmp.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    for (int j = 0; j < tmp.size() && j < limit; j++) exp_q.push_back(tmp[j]);
  endtask

  task automatic compare(input string tag, input logic [W-1:0] got);
    logic [W-1:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s no expected value queued, observed=%h", tag, got);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      assert (got === e) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, got, e);
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    compare(tag, obs1());
  endtask

  task automatic step2(input string tag);
    @(posedge clk);
    #1;
    compare(tag, obs2());
  endtask

  task automatic do_steps(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    bus.start = 1'b0;  bus.sample_sel = '0;  bus.abort = 1'b0;
    bus2.start = 1'b0; bus2.sample_sel = '0; bus2.abort = 1'b0;
`ifdef NAP_SEQ_PAUSE_EN
    bus.pause = 1'b0;
    bus2.pause = 1'b0;
`endif

    repeat (2) @(posedge clk);
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    step("reset");
    checks++;
    assert (bus.state_dbg === 4'd0) else begin
      errors++;
      $error("FAIL reset_state observed=%0d expected=0", bus.state_dbg);
    end
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    step2("reset_dut2");
    rst = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    step("idle");

    // Full run on channel 3; done lands on the 477th clock of the run.
    bus.sample_sel = 3'd3; bus.start = 1'b1;
    push_run(3, 1000, -1, 0);
    step("run_sel3");
    bus.start = 1'b0;
    do_steps(477, "run_sel3");

    // Top channel, with a stray start mid-run that must not disturb anything.
    bus.sample_sel = 3'd7; bus.start = 1'b1;
    push_run(7, 1000, -1, 0);
    step("run_sel7");
    bus.start = 1'b0;
    do_steps(99, "run_sel7");
    bus.start = 1'b1; bus.sample_sel = 3'd2;
    step("run_sel7_ignored_start");
    bus.start = 1'b0;
    do_steps(377, "run_sel7");

    // Out-of-range channel on the 4-bit-select instance.
    bus2.sample_sel = 4'd9; bus2.start = 1'b1;
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    step2("err_sel9");
    bus2.start = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    step2("err_sel9_after");

    // Reset taken in the middle of LYSIS.
    bus.sample_sel = 3'd5; bus.start = 1'b1;
    push_run(5, 105, -1, 0);
    step("run_rst");
    bus.start = 1'b0;
    do_steps(104, "run_rst");
    rst = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    step("mid_reset");
    rst = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    step("post_reset_idle");

    // Abort sampled on the 10th WASH clock.
    bus.sample_sel = 3'd1; bus.start = 1'b1;
    push_run(1, 340, -1, 0);
    step("run_abort");
    bus.start = 1'b0;
    do_steps(339, "run_abort");
    bus.abort = 1'b1;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    step("abort_taken");
    bus.abort = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 11'h0, 3'b111));
    step("abort_after");

    bus.sample_sel = 3'd0; bus.start = 1'b1;
    push_run(0, 1000, -1, 0);
    step("run_after_abort");
    bus.start = 1'b0;
    do_steps(477, "run_after_abort");

`ifdef NAP_SEQ_PAUSE_EN
    // Pause after the 6th MIX clock (mid-phase) for 20 clocks.
    bus.sample_sel = 3'd3; bus.start = 1'b1;
    push_run(3, 1000, 5, 20);
    step("run_pause");
    bus.start = 1'b0;
    do_steps(123, "run_pause");
    bus.pause = 1'b1;
    do_steps(20, "run_pause_held");
    bus.pause = 1'b0;
    do_steps(354, "run_pause");
`endif

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL leftover_expected observed=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
